muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that sits directly downstream of the register file.
- Consumes ReadData1/ReadData2 as operands `a`/`b` for MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers and exposes them for MFHI/MFLO write-back.
- Provides a start/busy/done handshake so control can stall while an operation runs.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  operand 1 (ReadData1): multiplicand or dividend.
- b  input  WIDTH  operand 2 (ReadData2): multiplier or divisor.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse on the cycle HI/LO hold a new result.
- hi  output  WIDTH  HI register (MULT: upper product; DIV: remainder).
- lo  output  WIDTH  LO register (MULT: lower product; DIV: quotient).

Behaviour:
- Reset: rst_n=0 at a rising edge sets state=IDLE, busy=0, done=0, hi=0, lo=0, and clears the counter and internal registers.
  - Reset is synchronous only; rst_n has no effect between edges.
  - Reset mid-operation aborts the operation; no result is written.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at an edge latches op, |a| and |b| (absolute values for signed ops, raw values for unsigned) and the sign bits.
  - Loads the counter with WIDTH, sets busy=1 and moves to RUN.
- RUN:
  - Performs one iteration per edge and decrements the counter.
  - When the counter reaches 1 on that edge, the next state is FINISH.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, WIDTH-bit remainder plus 1 guard bit.
- FINISH:
  - Applies sign correction and writes hi/lo.
  - Sets done=1 and busy=0, then returns to IDLE.
  - done falls on the next edge.
- Latency: accept edge E0; iterations E1..E_WIDTH; result and done at E_(WIDTH+1).
  - For WIDTH=32 the result is visible 33 edges after accept.
  - The earliest next accept is E_(WIDTH+2).
- start while busy=1 is ignored and not queued; operands are not resampled.
- Sign rules:
  - MULT: product negated (2*WIDTH two's complement) when sign(a) != sign(b).
  - DIV: quotient negated when signs differ; remainder takes the sign of the dividend.
  - DIV with most-negative / -1: quotient = most-negative, remainder = 0 (wrap, no trap).
- Divide by zero (b=0, DIV or DIVU):
  - Runs the full latency.
  - Result is lo = all ones and hi = a as originally presented, for both signedness modes.
- MTHI/MTLO:
  - hi_we/lo_we are honoured only when busy=0 and state is not FINISH; otherwise they are ignored.
  - hi_we and lo_we may both be set in the same cycle; both registers then take wdata.
  - start together with hi_we/lo_we in IDLE: the write is applied on that edge, the operation is accepted, and its result later overwrites HI/LO.
- hi/lo hold their value through RUN; they change only in FINISH, on MTHI/MTLO, or on reset.
- op values are fully decoded; there are no illegal codes.

Test Plan:
- Reset, then MULT a=FFFFFFFD (-3), b=00000005 -> done exactly 33 edges after accept; hi=FFFFFFFF, lo=FFFFFFF1; busy high for 33 cycles.
- MULTU a=FFFFFFFF, b=00000002 -> hi=00000001, lo=FFFFFFFE. Then back-to-back DIVU a=00000064, b=00000007 issued the cycle after done -> lo=0000000E, hi=00000002.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
- DIVU and DIV with b=0, a=12345678 -> lo=FFFFFFFF, hi=12345678 after full latency. A second start pulsed mid-run is ignored: exactly one done, result unchanged.
- MTHI wdata=AAAA5555 in IDLE -> hi=AAAA5555. MTLO during busy -> lo unchanged. start+lo_we together in IDLE -> lo=wdata next edge, then the operation result at done.
- rst_n=0 for one edge at iteration 10 of a MULT -> busy=0, done never pulses, hi=lo=0. A new MULT 00000007*00000006 afterwards -> lo=0000002A, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------------------------
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO registers.
//
// Operands come straight from the register file read ports. One operation runs at a time:
// an accept edge, WIDTH iteration edges, and a finish edge that writes HI/LO and pulses done.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   rst_n  - synchronous active-low reset
//   start  - request a new operation, sampled only while idle
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   - operand 1 (multiplicand / dividend), operand 2 (multiplier / divisor)
//   hi_we  - MTHI write enable (ignored while an operation is in flight)
//   lo_we  - MTLO write enable (ignored while an operation is in flight)
//   wdata  - MTHI/MTLO data
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse on the cycle HI/LO first hold a new result
//   hi, lo - HI/LO registers (MULT: upper/lower product, DIV: remainder/quotient)
// ---------------------------------------------------------------------------------------------
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Multiply: {upper product, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand for multiply, divisor for divide (magnitudes).
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // Dividend as presented, returned in HI on divide by zero.
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // ---------------------------------------------------------------------------
  // Operand preparation at accept time
  // ---------------------------------------------------------------------------
  logic             in_signed;
  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_abs, b_abs;

  // op[0] = 1 selects the unsigned variant.
  assign in_signed = ~op[0];
  assign a_neg_in  = in_signed & a[WIDTH-1];
  assign b_neg_in  = in_signed & b[WIDTH-1];
  // The most-negative value maps onto itself, which reads correctly as an unsigned magnitude.
  assign a_abs     = a_neg_in ? -a : a;
  assign b_abs     = b_neg_in ? -b : b;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic               is_div, is_signed;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // Shift-add: add the multiplicand into the upper half when the current multiplier bit is set,
  // then shift the whole accumulator right, keeping the carry as the new top bit.
  assign mul_addend = acc_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder; the extra guard bit keeps
  // the shifted remainder exact before the trial subtraction.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_next  = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // ---------------------------------------------------------------------------
  // Result sign correction
  // ---------------------------------------------------------------------------
  logic               signs_differ;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_raw, rem_raw;
  logic [WIDTH-1:0]   quo_res, rem_res;
  logic               div_by_zero;

  assign signs_differ = is_signed & (sign_a_q ^ sign_b_q);
  assign mul_res      = signs_differ ? -acc_q : acc_q;
  assign quo_raw      = acc_q[WIDTH-1:0];
  assign rem_raw      = acc_q[2*WIDTH-1:WIDTH];
  // Most-negative / -1 yields a magnitude of 2^(WIDTH-1); negating it wraps back onto itself.
  assign quo_res      = signs_differ ? -quo_raw : quo_raw;
  // Remainder follows the dividend's sign.
  assign rem_res      = (is_signed & sign_a_q) ? -rem_raw : rem_raw;
  assign div_by_zero  = (opnd_q == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        // MTHI/MTLO land on this edge even when an operation is accepted alongside; the
        // operation's result overwrites them later.
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d     = op;
          sign_a_d = a_neg_in;
          sign_b_d = b_neg_in;
          a_raw_d  = a;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = StRun;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, a_abs};
            opnd_d = b_abs;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_abs};
            opnd_d = a_abs;
          end
        end
      end

      StRun: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StFinish;
      end

      StFinish: begin
        if (!is_div) begin
          hi_d = mul_res[2*WIDTH-1:WIDTH];
          lo_d = mul_res[WIDTH-1:0];
        end else if (div_by_zero) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_res;
          lo_d = quo_res;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_muldiv_unit: directed plus a few random operations for muldiv_unit. Expected HI/LO values
// are queued when an operation is issued and popped when done pulses.
// ---------------------------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int unsigned W = 32;
  localparam int Lat = 33;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  muldiv_unit #(
    .WIDTH(W),
    .CNT_W(6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint p;
    int     sx, sy;
    logic [31:0] q, r;
    case (o)
      2'b00: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      2'b01: return {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sx = x;
        sy = y;
        q  = sx / sy;
        r  = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Drive one accept edge; leaves the bench at accept edge + 1.
  task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit push, input logic [63:0] exp);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) sb_q.push_back(exp);
    tick();
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check({tag, "/busy_after_accept"}, 64'(busy), 64'd1);
    check({tag, "/done_after_accept"}, 64'(done), 64'd0);
  endtask

  // Wait for done; elapsed = edges already seen since the accept edge.
  task automatic wait_done(input string tag, input int elapsed);
    int cycles;
    int busy_cnt;
    logic [63:0] exp;
    cycles   = elapsed;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      cycles++;
    end
    check({tag, "/latency"}, 64'(cycles), 64'(Lat));
    check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(Lat - elapsed));
    check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "/sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check({tag, "/hi"}, 64'(hi), 64'(exp[63:32]));
      check({tag, "/lo"}, 64'(lo), 64'(exp[31:0]));
    end
  endtask

  task automatic after_done(input string tag);
    tick();
    check({tag, "/done_fell"}, 64'(done), 64'd0);
    check({tag, "/idle"}, 64'(busy), 64'd0);
  endtask

  task automatic quiet(input string tag, input int n);
    int d;
    d = 0;
    repeat (n) begin
      tick();
      if (done === 1'b1) d++;
    end
    check({tag, "/no_done"}, 64'(d), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/hi", 64'(hi), 64'd0);
    check("reset/lo", 64'(lo), 64'd0);

    // MULT -3 * 5
    issue("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_done("mult_neg", 0);
    after_done("mult_neg");

    // MULTU then DIVU issued on the cycle done is high
    issue("multu", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'h0000_0001_FFFF_FFFE);
    wait_done("multu", 0);
    issue("divu_b2b", 2'b11, 32'h0000_0064, 32'h0000_0007, 1'b1, 64'h0000_0002_0000_000E);
    wait_done("divu_b2b", 0);
    after_done("divu_b2b");

    // Signed divides
    issue("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done("div_neg", 0);
    after_done("div_neg");
    issue("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
    wait_done("div_ovf", 0);
    after_done("div_ovf");

    // Divide by zero, both signedness modes; second start mid-run is ignored
    issue("divu_zero", 2'b11, 32'h1234_5678, 32'h0000_0000, 1'b1, 64'h1234_5678_FFFF_FFFF);
    wait_done("divu_zero", 0);
    after_done("divu_zero");
    issue("div_zero", 2'b10, 32'h1234_5678, 32'h0000_0000, 1'b1, 64'h1234_5678_FFFF_FFFF);
    repeat (4) tick();
    op    = 2'b01;
    a     = 32'h0000_0001;
    b     = 32'h0000_0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("div_zero", 5);
    after_done("div_zero");
    quiet("div_zero", 40);

    // MTHI in idle
    hi_we = 1'b1;
    wdata = 32'hAAAA_5555;
    tick();
    hi_we = 1'b0;
    check("mthi/hi", 64'(hi), 64'h0000_0000_AAAA_5555);
    check("mthi/lo_kept", 64'(lo), 64'h0000_0000_FFFF_FFFF);

    // MTLO while busy is ignored; HI/LO hold through RUN
    issue("mtlo_busy", 2'b01, 32'h0000_0003, 32'h0000_0004, 1'b1, 64'h0000_0000_0000_000C);
    repeat (3) tick();
    lo_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    tick();
    lo_we = 1'b0;
    check("mtlo_busy/lo_held", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    check("mtlo_busy/hi_held", 64'(hi), 64'h0000_0000_AAAA_5555);
    wait_done("mtlo_busy", 4);
    after_done("mtlo_busy");

    // start + lo_we together in idle
    lo_we = 1'b1;
    wdata = 32'h1357_2468;
    issue("start_mtlo", 2'b11, 32'h0000_0009, 32'h0000_0004, 1'b1, 64'h0000_0001_0000_0002);
    check("start_mtlo/lo_written", 64'(lo), 64'h0000_0000_1357_2468);
    wait_done("start_mtlo", 0);
    after_done("start_mtlo");

    // Random operations against the model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 2);
      issue("rand", ro, ra, rb, 1'b1, model(ro, ra, rb));
      wait_done("rand", 0);
      after_done("rand");
    end

    // Reset in the middle of a MULT aborts it
    issue("mult_abort", 2'b00, 32'h0000_0005, 32'h0000_0005, 1'b0, 64'h0);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mult_abort/busy", 64'(busy), 64'd0);
    check("mult_abort/done", 64'(done), 64'd0);
    check("mult_abort/hi", 64'(hi), 64'd0);
    check("mult_abort/lo", 64'(lo), 64'd0);
    quiet("mult_abort", 40);

    issue("mult_post", 2'b00, 32'h0000_0007, 32'h0000_0006, 1'b1, 64'h0000_0000_0000_002A);
    wait_done("mult_post", 0);
    after_done("mult_post");

    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
